vga_framebuffer_arbiter: RTL and testbench
==========================================

Name: vga_framebuffer_arbiter

Overview:
- Shares one single-port pixel memory between two requesters: the VGA display scan-out and a host port used to load or inspect the image.
- Prefetches display pixels into an internal FIFO so scan-out never waits on memory latency.
- Schedules host accesses into idle or slack memory cycles.
- Sits between the ViewImage pixel pipeline and the framebuffer RAM, clocked by the ClockManager clock0 domain.

Parameters:
- AW, 15, memory word address width.
- DW, 3, data width; one RGB pixel per word.
- FRAME_WORDS, 19200, words per frame (160x120); display address wraps after FRAME_WORDS-1.
- FIFO_DEPTH, 4, display prefetch FIFO entries; power of two, at least 2.
- LOW_WATER, 2, display urgency threshold; must be less than FIFO_DEPTH.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of frame.
- pix_pop  in  1  display consumer takes the head pixel.
- pix_data  out  DW  FIFO head pixel.
- pix_valid  out  1  FIFO non-empty.
- underrun  out  1  one-cycle pulse when pix_pop arrives while FIFO is empty.
- host_req  in  1  host access request; held until host_ack.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  AW  host word address.
- host_wdata  in  DW  host write data.
- host_ack  out  1  one-cycle pulse; access issued to memory this cycle.
- host_rdata  out  DW  host read data.
- host_rvalid  out  1  one-cycle pulse; host_rdata valid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid in the cycle after a read mem_en.

Behaviour:
- Reset (reset=0, async): all outputs 0, FIFO empty, display address 0, no reads in flight.
- Memory access: at most one per cycle. mem_* and host_ack are registered. The decision made in cycle t drives mem_* and host_ack in cycle t+1 (issue cycle E).
- Credit: occ = FIFO level + display reads in flight (0..FIFO_DEPTH). Display may issue only if occ < FIFO_DEPTH.
- Priority, evaluated each cycle:
  - (1) If occ < LOW_WATER, display is urgent and wins.
  - (2) Otherwise host_req wins.
  - (3) Otherwise display issues if credit is available.
  - (4) Otherwise idle, with mem_en=0.
- host_req is ignored in any cycle where host_ack=1, so a single request is never granted twice.
- Display read: mem_addr = display address; the address then increments, wrapping from FRAME_WORDS-1 to 0. mem_rdata is pushed into the FIFO at the end of cycle E+1.
- Host write: mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata in cycle E.
- Host read: mem_we=0 in cycle E. host_rdata is captured from mem_rdata; host_rvalid is asserted in cycle E+2.
- FIFO:
  - pix_data and pix_valid reflect the head combinationally from FIFO registers.
  - Pop and fill in the same cycle leave the level unchanged.
  - pix_pop while empty is ignored and raises underrun for one cycle.
- frame_start:
  - At the end of that cycle the FIFO is flushed and the display address is set to 0.
  - Display reads in flight are tagged stale and their data is dropped.
  - No display read is decided in the frame_start cycle.
  - frame_start overrides a simultaneous pix_pop.
  - Host transactions in flight complete normally.
- Starvation: host may wait indefinitely only if the display keeps occ < LOW_WATER. That requires popping every cycle, which is outside the VGA budget of 1 pop per 4 clocks.

Test Plan:
- Release reset, host idle, no pops -> mem_en reads at addresses 0,1,2,3 on consecutive cycles, then mem_en=0. pix_valid rises 2 cycles after the first mem_en; FIFO level settles at 4.
- FIFO full; host_req, we=1, addr=0x0100, wdata=5 -> host_ack pulses once; the same cycle shows mem_we=1, mem_addr=0x0100, mem_wdata=5; no second ack while req is still high.
- Level 1 and host_req pending together -> display read issued first; host_ack follows once occ >= 2; pixel order is preserved.
- Word 0x0042 preloaded with 3; host read of 0x0042 -> host_rvalid=1 with host_rdata=3 exactly 2 cycles after that mem_en.
- Wrap: FRAME_WORDS=8, pop every 4th cycle -> display mem_addr sequence 0..7,0,1,...; pix_data matches memory contents.
- frame_start with 2 reads in flight, then pix_pop while empty -> pix_valid=0 next cycle, stale data never appears, next display mem_addr=0, and the pop yields underrun=1 for exactly one cycle.

Source files
------------

// File: rtl/vga_framebuffer_arbiter.sv
// Arbitrates one single-port pixel RAM between display scan-out (prefetched into a small FIFO)
// and a host load/inspect port. One access per cycle; decisions are registered onto mem_*.
module vga_framebuffer_arbiter #(
    parameter int AW          = 15,
    parameter int DW          = 3,
    parameter int FRAME_WORDS = 19200,
    parameter int FIFO_DEPTH  = 4,
    parameter int LOW_WATER   = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          pix_pop,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    output logic          underrun,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 2;

    logic [DW-1:0] r_fifo [FIFO_DEPTH];
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic [AW-1:0] r_disp_addr;
    logic          r_disp_e;
    logic          r_disp_e1;
    logic          r_host_rd_e;
    logic          r_host_rd_e1;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_host_ack;
    logic [DW-1:0] r_host_rdata;
    logic          r_host_rvalid;
    logic          r_underrun;

    logic [PW:0]   w_level;
    logic [OW-1:0] w_occ;
    logic          w_push;
    logic          w_pop;
    logic          w_host_ok;
    logic          w_disp_ok;
    logic          w_urgent;
    logic          w_sel_host;
    logic          w_sel_disp;
    logic [AW-1:0] w_disp_addr_nxt;

    // Credit counts display reads already decided but not yet landed, so the FIFO can never overflow.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_occ   = OW'(w_level) + OW'(r_disp_e) + OW'(r_disp_e1);

    assign pix_valid = (w_level != '0);
    assign pix_data  = pix_valid ? r_fifo[r_rd_ptr[PW-1:0]] : '0;

    // Stale (pre-frame_start) reads have had their in-flight flags cleared, so they never push.
    assign w_push = r_disp_e1 & ~frame_start;
    assign w_pop  = pix_pop & pix_valid & ~frame_start;

    assign w_disp_addr_nxt = (r_disp_addr == AW'(FRAME_WORDS - 1)) ? '0 : r_disp_addr + AW'(1);

    always_comb begin
        w_host_ok  = host_req & ~r_host_ack;
        w_disp_ok  = ~frame_start & (w_occ < OW'(FIFO_DEPTH));
        w_urgent   = w_disp_ok & (w_occ < OW'(LOW_WATER));
        w_sel_host = w_host_ok & ~w_urgent;
        w_sel_disp = w_disp_ok & ~w_sel_host;
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[PW-1:0]] <= mem_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_disp_addr   <= '0;
            r_disp_e      <= 1'b0;
            r_disp_e1     <= 1'b0;
            r_host_rd_e   <= 1'b0;
            r_host_rd_e1  <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_host_ack    <= 1'b0;
            r_host_rdata  <= '0;
            r_host_rvalid <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            if (frame_start) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_disp_addr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_sel_disp) r_disp_addr <= w_disp_addr_nxt;
            end

            r_disp_e  <= w_sel_disp;
            r_disp_e1 <= r_disp_e & ~frame_start;

            r_mem_en    <= w_sel_disp | w_sel_host;
            r_mem_we    <= w_sel_host & host_we;
            r_mem_addr  <= w_sel_host ? host_addr : r_disp_addr;
            r_mem_wdata <= w_sel_host ? host_wdata : '0;
            r_host_ack  <= w_sel_host;

            // Host reads return two cycles after issue, independent of frame_start.
            r_host_rd_e   <= w_sel_host & ~host_we;
            r_host_rd_e1  <= r_host_rd_e;
            r_host_rvalid <= r_host_rd_e1;
            if (r_host_rd_e1) r_host_rdata <= mem_rdata;

            r_underrun <= pix_pop & ~pix_valid & ~frame_start;
        end
    end

    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign host_ack    = r_host_ack;
    assign host_rdata  = r_host_rdata;
    assign host_rvalid = r_host_rvalid;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_vga_framebuffer_arbiter.sv
// Directed bench for vga_framebuffer_arbiter with a small behavioural RAM (word i holds (i+1) mod 8).
module tb_vga_framebuffer_arbiter;

    localparam int AW = 15;
    localparam int DW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          pix_pop;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          underrun;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    vga_framebuffer_arbiter #(
        .AW(AW), .DW(DW), .FRAME_WORDS(8), .FIFO_DEPTH(4), .LOW_WATER(2)
    ) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .pix_pop(pix_pop), .pix_data(pix_data), .pix_valid(pix_valid), .underrun(underrun),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Single-port RAM: read data appears the cycle after a read strobe.
    logic [DW-1:0] ram [0:511];
    logic          ram_init = 1'b0;
    always @(posedge clock) begin
        if (!ram_init) begin
            for (int i = 0; i < 512; i++) ram[i] <= 3'(i + 1);
            ram_init  <= 1'b1;
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr[8:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[8:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    int q_addr[$];
    int q_pix[$];
    int n_under;

    initial begin
        reset = 1'b0; frame_start = 1'b0; pix_pop = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        step(3);
        check_eq("rst_mem_en",    32'(mem_en), 0);
        check_eq("rst_mem_addr",  32'(mem_addr), 0);
        check_eq("rst_pix_valid", 32'(pix_valid), 0);
        check_eq("rst_pix_data",  32'(pix_data), 0);
        check_eq("rst_host_ack",  32'(host_ack), 0);
        check_eq("rst_rvalid",    32'(host_rvalid), 0);
        check_eq("rst_rdata",     32'(host_rdata), 0);
        check_eq("rst_underrun",  32'(underrun), 0);

        // Fill after reset: four back-to-back display reads.
        reset = 1'b1;
        step(1);
        check_eq("fill_en0",   32'(mem_en), 1);
        check_eq("fill_we0",   32'(mem_we), 0);
        check_eq("fill_addr0", 32'(mem_addr), 0);
        check_eq("fill_val0",  32'(pix_valid), 0);
        step(1);
        check_eq("fill_addr1", 32'(mem_addr), 1);
        check_eq("fill_val1",  32'(pix_valid), 0);
        step(1);
        check_eq("fill_addr2", 32'(mem_addr), 2);
        check_eq("fill_val2",  32'(pix_valid), 1);
        check_eq("fill_pix2",  32'(pix_data), 1);
        step(1);
        check_eq("fill_addr3", 32'(mem_addr), 3);
        step(1);
        check_eq("fill_idle",  32'(mem_en), 0);
        step(4);
        check_eq("full_idle",  32'(mem_en), 0);
        check_eq("full_pix",   32'(pix_data), 1);

        // Host write with FIFO full.
        host_req = 1'b1; host_we = 1'b1; host_addr = 15'h0100; host_wdata = 3'd5;
        step(1);
        check_eq("wr_ack",   32'(host_ack), 1);
        check_eq("wr_en",    32'(mem_en), 1);
        check_eq("wr_we",    32'(mem_we), 1);
        check_eq("wr_addr",  32'(mem_addr), 32'h0100);
        check_eq("wr_wdata", 32'(mem_wdata), 5);
        step(1);
        check_eq("wr_noack2", 32'(host_ack), 0);
        check_eq("wr_noen2",  32'(mem_en), 0);
        host_req = 1'b0; host_we = 1'b0;
        step(1);
        check_eq("wr_noack3", 32'(host_ack), 0);

        // Host read of 0x0042 (holds 3).
        host_req = 1'b1; host_addr = 15'h0042;
        step(1);
        check_eq("rd_ack",  32'(host_ack), 1);
        check_eq("rd_we",   32'(mem_we), 0);
        check_eq("rd_addr", 32'(mem_addr), 32'h0042);
        host_req = 1'b0;
        step(1);
        check_eq("rd_rv_e1", 32'(host_rvalid), 0);
        step(1);
        check_eq("rd_rv_e2", 32'(host_rvalid), 1);
        check_eq("rd_data",  32'(host_rdata), 3);
        step(1);
        check_eq("rd_rv_e3", 32'(host_rvalid), 0);

        // Read back the word written above.
        host_req = 1'b1; host_addr = 15'h0100;
        step(1);
        check_eq("rb_ack", 32'(host_ack), 1);
        host_req = 1'b0;
        step(2);
        check_eq("rb_rv",   32'(host_rvalid), 1);
        check_eq("rb_data", 32'(host_rdata), 5);

        // Urgent display beats a pending host request after a flush.
        step(2);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        check_eq("pr_flush_val", 32'(pix_valid), 0);
        check_eq("pr_fs_noen",   32'(mem_en), 0);
        host_req = 1'b1; host_we = 1'b1; host_addr = 15'h0101; host_wdata = 3'd6;
        step(1);
        check_eq("pr_d0_addr", 32'(mem_addr), 0);
        check_eq("pr_d0_en",   32'(mem_en), 1);
        check_eq("pr_d0_ack",  32'(host_ack), 0);
        step(1);
        check_eq("pr_d1_addr", 32'(mem_addr), 1);
        check_eq("pr_d1_ack",  32'(host_ack), 0);
        step(1);
        check_eq("pr_h_ack",   32'(host_ack), 1);
        check_eq("pr_h_we",    32'(mem_we), 1);
        check_eq("pr_h_addr",  32'(mem_addr), 32'h0101);
        check_eq("pr_h_wdata", 32'(mem_wdata), 6);
        check_eq("pr_h_pix",   32'(pix_data), 1);
        host_req = 1'b0; host_we = 1'b0;
        step(1);
        check_eq("pr_d2_addr", 32'(mem_addr), 2);
        check_eq("pr_d2_ack",  32'(host_ack), 0);
        step(10);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("pr_order%0d", i), 32'(pix_data), 32'((i + 1) % 8));
            pix_pop = 1'b1;
            step(1);
        end
        pix_pop = 1'b0;

        // frame_start with two display reads in flight, then a pop while empty.
        step(10);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        step(1);
        check_eq("fs_a0", 32'(mem_addr), 0);
        step(1);
        check_eq("fs_a1", 32'(mem_addr), 1);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        check_eq("fs_val0", 32'(pix_valid), 0);
        check_eq("fs_noen", 32'(mem_en), 0);
        pix_pop = 1'b1;
        step(1);
        pix_pop = 1'b0;
        check_eq("fs_under1", 32'(underrun), 1);
        check_eq("fs_en",     32'(mem_en), 1);
        check_eq("fs_addr",   32'(mem_addr), 0);
        check_eq("fs_val1",   32'(pix_valid), 0);
        step(1);
        check_eq("fs_under2", 32'(underrun), 0);
        check_eq("fs_val2",   32'(pix_valid), 0);
        step(1);
        check_eq("fs_val3",   32'(pix_valid), 1);
        check_eq("fs_pix",    32'(pix_data), 1);

        // Address wrap over an 8-word frame with a pop every 4th cycle.
        step(10);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        n_under = 0;
        for (int c = 0; c < 100; c++) begin
            if (mem_en && !mem_we) q_addr.push_back(int'(mem_addr));
            if (underrun) n_under++;
            if ((c % 4) == 3 && pix_valid) begin
                q_pix.push_back(int'(pix_data));
                pix_pop = 1'b1;
            end else begin
                pix_pop = 1'b0;
            end
            step(1);
        end
        pix_pop = 1'b0;
        check_eq("wrap_naddr", 32'(q_addr.size() >= 20), 1);
        check_eq("wrap_npix",  32'(q_pix.size() >= 16), 1);
        check_eq("wrap_under", 32'(n_under), 0);
        for (int i = 0; i < 20 && i < q_addr.size(); i++)
            check_eq($sformatf("wrap_addr%0d", i), 32'(q_addr[i]), 32'(i % 8));
        for (int i = 0; i < 16 && i < q_pix.size(); i++)
            check_eq($sformatf("wrap_pix%0d", i), 32'(q_pix[i]), 32'(((i % 8) + 1) % 8));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
